// File: rtl/gpo_reg.sv
// gpo_reg: I2C write-path register bank driving general-purpose outputs.
// Two slave ports share sixteen 8-bit output registers. Each port commits one
// write per chip-select assertion, on the rising edge of its write qualifier.
// Registers flagged in PULSE_MASK are self-clearing: they hold the written data
// for PULSE_LEN cycles and then return to their reset value.
// Optional feature macro: GPO_WPROT_EN. When defined, register 15 acts as a
// write-protect key; writing 8'hA5 unlocks registers 0..14, and any other
// value locks them again.

module gpo_reg #(
  parameter logic [127:0] RST_VAL    = 128'h0,
  parameter logic [15:0]  PULSE_MASK = 16'h0,
  parameter logic [7:0]   PULSE_LEN  = 8'd4
) (
  input  logic        SYSCLK,
  input  logic        RESET_N,
  input  logic        PORT_CS1,
  input  logic [15:0] OFFSET_SEL1,
  input  logic        RD_WR1,
  input  logic [7:0]  DIN1,
  input  logic        PORT_CS2,
  input  logic [15:0] OFFSET_SEL2,
  input  logic        RD_WR2,
  input  logic [7:0]  DIN2,
  output logic [7:0]  DOUT0,
  output logic [7:0]  DOUT1,
  output logic [7:0]  DOUT2,
  output logic [7:0]  DOUT3,
  output logic [7:0]  DOUT4,
  output logic [7:0]  DOUT5,
  output logic [7:0]  DOUT6,
  output logic [7:0]  DOUT7,
  output logic [7:0]  DOUT8,
  output logic [7:0]  DOUT9,
  output logic [7:0]  DOUT10,
  output logic [7:0]  DOUT11,
  output logic [7:0]  DOUT12,
  output logic [7:0]  DOUT13,
  output logic [7:0]  DOUT14,
  output logic [7:0]  DOUT15,
  output logic [15:0] WR_STB,
  output logic        COLLIDE,
  output logic        WP_LOCKED
);

  localparam logic [7:0] WP_KEY = 8'hA5;

  logic        wq1;
  logic        wq2;
  logic        wq1_d;
  logic        wq2_d;
  logic        commit1;
  logic        commit2;
  logic [15:0] wr_allow;
  logic [15:0] sel1_ok;
  logic [15:0] sel2_ok;
  logic [15:0] overlap;
  logic [15:0] wr_mask;
  logic [7:0]  wr_data [16];
  logic [7:0]  dout_r  [16];
  logic [7:0]  cnt_r   [16];
  logic [15:0] wr_stb_r;
  logic        collide_r;

  // Write qualifiers: a port is writing when selected, in write direction,
  // and addressing at least one register.
  assign wq1 = PORT_CS1 & ~RD_WR1 & (|OFFSET_SEL1);
  assign wq2 = PORT_CS2 & ~RD_WR2 & (|OFFSET_SEL2);

  // Only the first cycle of a qualifier assertion commits, so holding CS
  // for many cycles still produces a single write.
  assign commit1 = wq1 & ~wq1_d;
  assign commit2 = wq2 & ~wq2_d;

`ifdef GPO_WPROT_EN
  logic wp_locked_r;

  // While locked only the key register (15) may be written.
  assign wr_allow  = wp_locked_r ? 16'h8000 : 16'hFFFF;
  assign WP_LOCKED = wp_locked_r;
`else
  assign wr_allow  = 16'hFFFF;
  assign WP_LOCKED = 1'b0;
`endif

  // Effective per-port write masks; discarded selects never count as overlap.
  assign sel1_ok = commit1 ? (OFFSET_SEL1 & wr_allow) : 16'h0000;
  assign sel2_ok = commit2 ? (OFFSET_SEL2 & wr_allow) : 16'h0000;
  assign overlap = sel1_ok & sel2_ok;
  assign wr_mask = sel1_ok | sel2_ok;

  // Per-register write data: port 1 wins any register both ports select.
  always_comb begin
    for (int n = 0; n < 16; n++) begin
      wr_data[n] = sel1_ok[n] ? DIN1 : DIN2;
    end
  end

  // Edge-detect flops for the write qualifiers.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wq1_d <= 1'b0;
      wq2_d <= 1'b0;
    end else begin
      wq1_d <= wq1;
      wq2_d <= wq2;
    end
  end

  // Register bank: writes load data (and reload pulse counters); pulse
  // registers count down and restore their reset value on the 1->0 step.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int n = 0; n < 16; n++) begin
        dout_r[n] <= RST_VAL[8*n +: 8];
        cnt_r[n]  <= 8'd0;
      end
    end else begin
      for (int n = 0; n < 16; n++) begin
        if (wr_mask[n]) begin
          dout_r[n] <= wr_data[n];
          cnt_r[n]  <= PULSE_MASK[n] ? PULSE_LEN : 8'd0;
        end else if (PULSE_MASK[n] && (cnt_r[n] != 8'd0)) begin
          cnt_r[n] <= cnt_r[n] - 8'd1;
          if (cnt_r[n] == 8'd1) begin
            dout_r[n] <= RST_VAL[8*n +: 8];
          end
        end
      end
    end
  end

  // Write strobe and collision flags, aligned with the updated outputs.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_stb_r  <= 16'h0000;
      collide_r <= 1'b0;
    end else begin
      wr_stb_r  <= wr_mask;
      collide_r <= |overlap;
    end
  end

`ifdef GPO_WPROT_EN
  // Key register writes update the lock; the new state gates the next commit.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wp_locked_r <= 1'b1;
    end else if (wr_mask[15]) begin
      wp_locked_r <= (wr_data[15] != WP_KEY);
    end
  end
`endif

  assign WR_STB  = wr_stb_r;
  assign COLLIDE = collide_r;

  assign DOUT0  = dout_r[0];
  assign DOUT1  = dout_r[1];
  assign DOUT2  = dout_r[2];
  assign DOUT3  = dout_r[3];
  assign DOUT4  = dout_r[4];
  assign DOUT5  = dout_r[5];
  assign DOUT6  = dout_r[6];
  assign DOUT7  = dout_r[7];
  assign DOUT8  = dout_r[8];
  assign DOUT9  = dout_r[9];
  assign DOUT10 = dout_r[10];
  assign DOUT11 = dout_r[11];
  assign DOUT12 = dout_r[12];
  assign DOUT13 = dout_r[13];
  assign DOUT14 = dout_r[14];
  assign DOUT15 = dout_r[15];

endmodule

// File: tb/tb_gpo_reg.sv
// tb_gpo_reg: directed bench for gpo_reg. Register 0 resets to 8'h5A and
// register 3 is a pulse register (PULSE_LEN=4) resetting to 8'h77.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_gpo_reg;

  logic        SYSCLK;
  logic        RESET_N;
  logic        port_cs1;
  logic [15:0] offset_sel1;
  logic        rd_wr1;
  logic [7:0]  din1;
  logic        port_cs2;
  logic [15:0] offset_sel2;
  logic        rd_wr2;
  logic [7:0]  din2;
  logic [7:0]  dout [16];
  logic [15:0] wr_stb;
  logic        collide;
  logic        wp_locked;

  int checks = 0;
  int errors = 0;

`ifdef GPO_WPROT_EN
  localparam logic LOCK_RST = 1'b1;
`else
  localparam logic LOCK_RST = 1'b0;
`endif

  gpo_reg #(
    .RST_VAL    (128'h0000_0000_0000_0000_0000_0000_7700_005A),
    .PULSE_MASK (16'h0008),
    .PULSE_LEN  (8'd4)
  ) dut (
    .SYSCLK      (SYSCLK),
    .RESET_N     (RESET_N),
    .PORT_CS1    (port_cs1),
    .OFFSET_SEL1 (offset_sel1),
    .RD_WR1      (rd_wr1),
    .DIN1        (din1),
    .PORT_CS2    (port_cs2),
    .OFFSET_SEL2 (offset_sel2),
    .RD_WR2      (rd_wr2),
    .DIN2        (din2),
    .DOUT0       (dout[0]),
    .DOUT1       (dout[1]),
    .DOUT2       (dout[2]),
    .DOUT3       (dout[3]),
    .DOUT4       (dout[4]),
    .DOUT5       (dout[5]),
    .DOUT6       (dout[6]),
    .DOUT7       (dout[7]),
    .DOUT8       (dout[8]),
    .DOUT9       (dout[9]),
    .DOUT10      (dout[10]),
    .DOUT11      (dout[11]),
    .DOUT12      (dout[12]),
    .DOUT13      (dout[13]),
    .DOUT14      (dout[14]),
    .DOUT15      (dout[15]),
    .WR_STB      (wr_stb),
    .COLLIDE     (collide),
    .WP_LOCKED   (wp_locked)
  );

  // Free-running system clock.
  initial begin
    SYSCLK = 1'b0;
    forever #5 SYSCLK = ~SYSCLK;
  end

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic cs1, input logic [15:0] sel1, input logic rw1,
                                input logic [7:0] d1, input logic cs2, input logic [15:0] sel2,
                                input logic rw2, input logic [7:0] d2);
    port_cs1    = cs1;
    offset_sel1 = sel1;
    rd_wr1      = rw1;
    din1        = d1;
    port_cs2    = cs2;
    offset_sel2 = sel2;
    rd_wr2      = rw2;
    din2        = d2;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0, 8'h00);
  endtask

  // Directed sequence.
  initial begin
    RESET_N = 1'b0;
    idle();
    repeat (2) @(negedge SYSCLK);
    check_output("rst_dout0", {8'h0, dout[0]}, 16'h005A);
    check_output("rst_dout3", {8'h0, dout[3]}, 16'h0077);
    check_output("rst_wr_stb", wr_stb, 16'h0000);
    check_output("rst_collide", {15'h0, collide}, 16'h0000);
    check_output("rst_wp_locked", {15'h0, wp_locked}, {15'h0, LOCK_RST});
    RESET_N = 1'b1;
    @(negedge SYSCLK);

`ifdef GPO_WPROT_EN
    apply_stimulus(1'b1, 16'h0001, 1'b0, 8'h99, 1'b0, 16'h0, 1'b0, 8'h00);
    @(negedge SYSCLK);
    check_output("wp_blocked_dout0", {8'h0, dout[0]}, 16'h005A);
    check_output("wp_blocked_stb", wr_stb, 16'h0000);
    idle();
    @(negedge SYSCLK);
    apply_stimulus(1'b1, 16'h8000, 1'b0, 8'hA5, 1'b0, 16'h0, 1'b0, 8'h00);
    @(negedge SYSCLK);
    check_output("wp_unlock", {15'h0, wp_locked}, 16'h0000);
    check_output("wp_key_stb", wr_stb, 16'h8000);
    check_output("wp_key_dout15", {8'h0, dout[15]}, 16'h00A5);
    idle();
    @(negedge SYSCLK);
`endif

    // Port-1 write held for 10 cycles: one commit only.
    apply_stimulus(1'b1, 16'h0004, 1'b0, 8'h3C, 1'b0, 16'h0, 1'b0, 8'h00);
    @(negedge SYSCLK);
    check_output("p1_dout2", {8'h0, dout[2]}, 16'h003C);
    check_output("p1_stb", wr_stb, 16'h0004);
    for (int i = 0; i < 9; i++) begin
      @(negedge SYSCLK);
      check_output("p1_hold_stb", wr_stb, 16'h0000);
    end
    check_output("p1_hold_dout2", {8'h0, dout[2]}, 16'h003C);
    idle();
    @(negedge SYSCLK);

    // Read access must not modify state.
    apply_stimulus(1'b1, 16'h0004, 1'b1, 8'h55, 1'b0, 16'h0, 1'b0, 8'h00);
    @(negedge SYSCLK);
    check_output("rd_dout2", {8'h0, dout[2]}, 16'h003C);
    check_output("rd_stb", wr_stb, 16'h0000);
    idle();
    @(negedge SYSCLK);

    // Overlapping simultaneous writes: port 1 wins register 1.
    apply_stimulus(1'b1, 16'h0003, 1'b0, 8'h11, 1'b1, 16'h0006, 1'b0, 8'h22);
    @(negedge SYSCLK);
    check_output("col_dout0", {8'h0, dout[0]}, 16'h0011);
    check_output("col_dout1", {8'h0, dout[1]}, 16'h0011);
    check_output("col_dout2", {8'h0, dout[2]}, 16'h0022);
    check_output("col_collide", {15'h0, collide}, 16'h0001);
    check_output("col_stb", wr_stb, 16'h0007);
    @(negedge SYSCLK);
    check_output("col_collide_end", {15'h0, collide}, 16'h0000);
    check_output("col_stb_end", wr_stb, 16'h0000);
    idle();
    @(negedge SYSCLK);

    // Disjoint simultaneous writes: no collision.
    apply_stimulus(1'b1, 16'h0010, 1'b0, 8'h44, 1'b1, 16'h0020, 1'b0, 8'h66);
    @(negedge SYSCLK);
    check_output("dis_dout4", {8'h0, dout[4]}, 16'h0044);
    check_output("dis_dout5", {8'h0, dout[5]}, 16'h0066);
    check_output("dis_collide", {15'h0, collide}, 16'h0000);
    check_output("dis_stb", wr_stb, 16'h0030);
    idle();
    @(negedge SYSCLK);

    // Pulse register: data held exactly 4 cycles, then reset value.
    apply_stimulus(1'b1, 16'h0008, 1'b0, 8'hFF, 1'b0, 16'h0, 1'b0, 8'h00);
    @(negedge SYSCLK);
    check_output("pulse_c1", {8'h0, dout[3]}, 16'h00FF);
    idle();
    for (int i = 2; i <= 4; i++) begin
      @(negedge SYSCLK);
      check_output("pulse_hold", {8'h0, dout[3]}, 16'h00FF);
    end
    @(negedge SYSCLK);
    check_output("pulse_restore", {8'h0, dout[3]}, 16'h0077);
    @(negedge SYSCLK);

    // Retrigger at cycle 2 extends hold to 4 cycles from the rewrite.
    apply_stimulus(1'b1, 16'h0008, 1'b0, 8'hFF, 1'b0, 16'h0, 1'b0, 8'h00);
    @(negedge SYSCLK);
    idle();
    @(negedge SYSCLK);
    check_output("retrig_c2", {8'h0, dout[3]}, 16'h00FF);
    apply_stimulus(1'b1, 16'h0008, 1'b0, 8'hEE, 1'b0, 16'h0, 1'b0, 8'h00);
    @(negedge SYSCLK);
    idle();
    check_output("retrig_r1", {8'h0, dout[3]}, 16'h00EE);
    for (int i = 2; i <= 4; i++) begin
      @(negedge SYSCLK);
      check_output("retrig_hold", {8'h0, dout[3]}, 16'h00EE);
    end
    @(negedge SYSCLK);
    check_output("retrig_restore", {8'h0, dout[3]}, 16'h0077);
    @(negedge SYSCLK);

`ifdef GPO_WPROT_EN
    // Relock with a non-key value, then a write to register 0 is discarded.
    apply_stimulus(1'b1, 16'h8000, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0, 8'h00);
    @(negedge SYSCLK);
    check_output("wp_relock", {15'h0, wp_locked}, 16'h0001);
    idle();
    @(negedge SYSCLK);
    apply_stimulus(1'b1, 16'h0001, 1'b0, 8'hC3, 1'b0, 16'h0, 1'b0, 8'h00);
    @(negedge SYSCLK);
    check_output("wp_relock_dout0", {8'h0, dout[0]}, 16'h0011);
    check_output("wp_relock_stb", wr_stb, 16'h0000);
    idle();
    @(negedge SYSCLK);
`endif

    // Reset mid-pulse: immediate restore, no late glitch after release.
    apply_stimulus(1'b1, 16'h0008, 1'b0, 8'hFF, 1'b0, 16'h0, 1'b0, 8'h00);
    @(negedge SYSCLK);
    check_output("mid_pulse_dout3", {8'h0, dout[3]}, 16'h00FF);
    idle();
    @(negedge SYSCLK);
    RESET_N = 1'b0;
    #1;
    check_output("async_rst_dout3", {8'h0, dout[3]}, 16'h0077);
    check_output("async_rst_dout0", {8'h0, dout[0]}, 16'h005A);
    @(negedge SYSCLK);
    RESET_N = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge SYSCLK);
      check_output("post_rst_dout3", {8'h0, dout[3]}, 16'h0077);
    end
    check_output("post_rst_wp_locked", {15'h0, wp_locked}, {15'h0, LOCK_RST});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
